// File: rtl/prv664_dispatch_sched.sv
// Dual-issue in-order dispatch scheduler: source-busy, intra-pair RAW and
// credit gating, itag assignment, scoreboard update and registered handoff.
module prv664_dispatch_sched #(
    parameter int unsigned IDLEN   = 8,
    parameter int unsigned CREDITS = 16
) (
    input  logic                           clk_i,
    input  logic                           srst_n_i,
    input  logic                           flush_i,
    input  logic                           inst0_valid_i,
    input  logic [4:0]                     inst0_rs1_i,
    input  logic [4:0]                     inst0_rs2_i,
    input  logic [4:0]                     inst0_rd_i,
    input  logic                           inst0_wren_i,
    input  logic                           inst1_valid_i,
    input  logic [4:0]                     inst1_rs1_i,
    input  logic [4:0]                     inst1_rs2_i,
    input  logic [4:0]                     inst1_rd_i,
    input  logic                           inst1_wren_i,
    output logic [1:0]                     accept_o,
    input  logic [31:0]                    busy_flag_i,
    output logic                           sb0_write_o,
    output logic [4:0]                     sb0_rdindex_o,
    output logic [IDLEN-1:0]               sb0_itag_o,
    output logic                           sb1_write_o,
    output logic [4:0]                     sb1_rdindex_o,
    output logic [IDLEN-1:0]               sb1_itag_o,
    output logic                           sb_clear_o,
    input  logic [1:0]                     retire_cnt_i,
    output logic                           disp0_valid_o,
    output logic [IDLEN-1:0]               disp0_itag_o,
    output logic [4:0]                     disp0_rd_o,
    output logic                           disp1_valid_o,
    output logic [IDLEN-1:0]               disp1_itag_o,
    output logic [4:0]                     disp1_rd_o,
    output logic [$clog2(CREDITS+1)-1:0]   inflight_o
);
    localparam int unsigned CW  = $clog2(CREDITS + 1);
    localparam int unsigned CXW = CW + 1;
    localparam logic [CXW-1:0] CRED_X = CXW'(CREDITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDLEN-1:0] next_itag_q;
    logic [CW-1:0]    inflight_q;
    logic [CXW-1:0]   inflight_x;
    logic [CXW-1:0]   infl_sum;
    logic [CXW-1:0]   infl_next;
    logic [IDLEN-1:0] itag0;
    logic [IDLEN-1:0] itag1;
    logic             raw01;
    logic             issue0;
    logic             issue1;

    // x0 is hardwired zero and can never be pending
    function automatic logic src_busy(input logic [31:0] vec, input logic [4:0] idx);
        return (idx != 5'd0) && vec[idx];
    endfunction

    assign inflight_x    = {1'b0, inflight_q};
    assign itag0         = next_itag_q;
    assign itag1         = next_itag_q + IDLEN'(1);
    assign inflight_o    = inflight_q;
    assign sb0_rdindex_o = inst0_rd_i;
    assign sb1_rdindex_o = inst1_rd_i;
    assign sb0_itag_o    = itag0;
    assign sb1_itag_o    = itag1;

    // slot 1 reading the register slot 0 is about to produce
    assign raw01 = inst0_wren_i && (inst0_rd_i != 5'd0) &&
                   ((inst1_rs1_i == inst0_rd_i) || (inst1_rs2_i == inst0_rd_i));

    // Next state, issue decision and scoreboard update requests
    always_comb begin
        state_d     = state_q;
        issue0      = 1'b0;
        issue1      = 1'b0;
        sb_clear_o  = 1'b1;
        accept_o    = 2'd0;
        sb0_write_o = 1'b0;
        sb1_write_o = 1'b0;

        case (state_q)
            IDLE:    state_d = RUN;
            RUN:     sb_clear_o = 1'b0;
            FLUSH:   if (!flush_i) state_d = RUN;
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = FLUSH;
        if (!srst_n_i) sb_clear_o = 1'b1;

        if (srst_n_i && (state_q == RUN) && !flush_i) begin
            issue0 = inst0_valid_i &&
                     !src_busy(busy_flag_i, inst0_rs1_i) &&
                     !src_busy(busy_flag_i, inst0_rs2_i) &&
                     (inflight_x < CRED_X);
            issue1 = issue0 && inst1_valid_i &&
                     !src_busy(busy_flag_i, inst1_rs1_i) &&
                     !src_busy(busy_flag_i, inst1_rs2_i) &&
                     !raw01 &&
                     ((inflight_x + CXW'(1)) < CRED_X);
        end

        accept_o    = {1'b0, issue0} + {1'b0, issue1};
        sb0_write_o = issue0 && inst0_wren_i && (inst0_rd_i != 5'd0);
        sb1_write_o = issue1 && inst1_wren_i && (inst1_rd_i != 5'd0);
    end

    // In-flight count after this cycle's accepts and retires, floored at zero
    always_comb begin
        infl_sum  = inflight_x + CXW'(accept_o);
        infl_next = (infl_sum > CXW'(retire_cnt_i)) ? (infl_sum - CXW'(retire_cnt_i)) : '0;
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // itag allocator, credit counter and dispatch handoff registers
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            next_itag_q   <= '0;
            inflight_q    <= '0;
            disp0_valid_o <= 1'b0;
            disp1_valid_o <= 1'b0;
            disp0_itag_o  <= '0;
            disp1_itag_o  <= '0;
            disp0_rd_o    <= 5'd0;
            disp1_rd_o    <= 5'd0;
        end else begin
            next_itag_q   <= next_itag_q + IDLEN'(accept_o);
            inflight_q    <= flush_i ? '0 : CW'(infl_next);
            disp0_valid_o <= issue0;
            disp1_valid_o <= issue1;
            disp0_itag_o  <= itag0;
            disp1_itag_o  <= itag1;
            disp0_rd_o    <= inst0_rd_i;
            disp1_rd_o    <= inst1_rd_i;
        end
    end

endmodule

// File: tb/tb_prv664_dispatch_sched.sv
// Self-checking bench for prv664_dispatch_sched: directed scenarios with
// hand-computed expectations plus a randomized run against a behavioural model.
module tb_prv664_dispatch_sched;
    localparam int unsigned IDLEN    = 8;
    localparam int unsigned CREDITS  = 16;
    localparam int unsigned CW       = $clog2(CREDITS + 1);
    localparam int          ITAG_MOD = 1 << IDLEN;

    logic             clk_i = 1'b0;
    logic             srst_n_i;
    logic             flush_i;
    logic             inst0_valid_i, inst0_wren_i;
    logic [4:0]       inst0_rs1_i, inst0_rs2_i, inst0_rd_i;
    logic             inst1_valid_i, inst1_wren_i;
    logic [4:0]       inst1_rs1_i, inst1_rs2_i, inst1_rd_i;
    logic [1:0]       accept_o;
    logic [31:0]      busy_flag_i;
    logic             sb0_write_o, sb1_write_o, sb_clear_o;
    logic [4:0]       sb0_rdindex_o, sb1_rdindex_o;
    logic [IDLEN-1:0] sb0_itag_o, sb1_itag_o;
    logic [1:0]       retire_cnt_i;
    logic             disp0_valid_o, disp1_valid_o;
    logic [IDLEN-1:0] disp0_itag_o, disp1_itag_o;
    logic [4:0]       disp0_rd_o, disp1_rd_o;
    logic [CW-1:0]    inflight_o;

    prv664_dispatch_sched #(.IDLEN(IDLEN), .CREDITS(CREDITS)) dut (
        .clk_i(clk_i), .srst_n_i(srst_n_i), .flush_i(flush_i),
        .inst0_valid_i(inst0_valid_i), .inst0_rs1_i(inst0_rs1_i), .inst0_rs2_i(inst0_rs2_i),
        .inst0_rd_i(inst0_rd_i), .inst0_wren_i(inst0_wren_i),
        .inst1_valid_i(inst1_valid_i), .inst1_rs1_i(inst1_rs1_i), .inst1_rs2_i(inst1_rs2_i),
        .inst1_rd_i(inst1_rd_i), .inst1_wren_i(inst1_wren_i),
        .accept_o(accept_o), .busy_flag_i(busy_flag_i),
        .sb0_write_o(sb0_write_o), .sb0_rdindex_o(sb0_rdindex_o), .sb0_itag_o(sb0_itag_o),
        .sb1_write_o(sb1_write_o), .sb1_rdindex_o(sb1_rdindex_o), .sb1_itag_o(sb1_itag_o),
        .sb_clear_o(sb_clear_o), .retire_cnt_i(retire_cnt_i),
        .disp0_valid_o(disp0_valid_o), .disp0_itag_o(disp0_itag_o), .disp0_rd_o(disp0_rd_o),
        .disp1_valid_o(disp1_valid_o), .disp1_itag_o(disp1_itag_o), .disp1_rd_o(disp1_rd_o),
        .inflight_o(inflight_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: "running" flag, next itag, credit count, expected handoff
    bit m_run;
    int m_itag;
    int m_infl;
    bit e_dv0, e_dv1;
    int e_di0, e_di1, e_dr0, e_dr1;
    bit x_ok0, x_ok1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit busy_m(input logic [31:0] v, input logic [4:0] i);
        return (i != 5'd0) && (v[i] == 1'b1);
    endfunction

    task automatic set_slots(input bit v0, input int a0, input int b0, input int d0, input bit w0,
                             input bit v1, input int a1, input int b1, input int d1, input bit w1);
        inst0_valid_i = v0; inst0_rs1_i = 5'(a0); inst0_rs2_i = 5'(b0);
        inst0_rd_i = 5'(d0); inst0_wren_i = w0;
        inst1_valid_i = v1; inst1_rs1_i = 5'(a1); inst1_rs2_i = 5'(b1);
        inst1_rd_i = 5'(d1); inst1_wren_i = w1;
    endtask

    task automatic model_comb();
        bit raw;
        x_ok0 = m_run && srst_n_i && !flush_i && inst0_valid_i &&
                !busy_m(busy_flag_i, inst0_rs1_i) && !busy_m(busy_flag_i, inst0_rs2_i) &&
                (m_infl < int'(CREDITS));
        raw = inst0_wren_i && (inst0_rd_i != 5'd0) &&
              ((inst1_rs1_i == inst0_rd_i) || (inst1_rs2_i == inst0_rd_i));
        x_ok1 = x_ok0 && inst1_valid_i && !raw &&
                !busy_m(busy_flag_i, inst1_rs1_i) && !busy_m(busy_flag_i, inst1_rs2_i) &&
                (m_infl + 1 < int'(CREDITS));
    endtask

    // Compare every output against the model, then advance one clock
    task automatic step();
        int acc;
        #1;
        model_comb();
        acc = int'(x_ok0) + int'(x_ok1);
        check("accept", 32'(accept_o), 32'(acc));
        check("sb_clear", 32'(sb_clear_o), 32'(!(srst_n_i && m_run)));
        check("sb0_write", 32'(sb0_write_o), 32'(x_ok0 && inst0_wren_i && inst0_rd_i != 5'd0));
        check("sb1_write", 32'(sb1_write_o), 32'(x_ok1 && inst1_wren_i && inst1_rd_i != 5'd0));
        if (x_ok0) begin
            check("sb0_itag", 32'(sb0_itag_o), 32'(m_itag));
            check("sb0_rdindex", 32'(sb0_rdindex_o), 32'(inst0_rd_i));
        end
        if (x_ok1) begin
            check("sb1_itag", 32'(sb1_itag_o), 32'((m_itag + 1) % ITAG_MOD));
            check("sb1_rdindex", 32'(sb1_rdindex_o), 32'(inst1_rd_i));
        end
        check("disp0_valid", 32'(disp0_valid_o), 32'(e_dv0));
        check("disp1_valid", 32'(disp1_valid_o), 32'(e_dv1));
        if (e_dv0) begin
            check("disp0_itag", 32'(disp0_itag_o), 32'(e_di0));
            check("disp0_rd", 32'(disp0_rd_o), 32'(e_dr0));
        end
        if (e_dv1) begin
            check("disp1_itag", 32'(disp1_itag_o), 32'(e_di1));
            check("disp1_rd", 32'(disp1_rd_o), 32'(e_dr1));
        end
        check("inflight", 32'(inflight_o), 32'(m_infl));
        @(posedge clk_i);
        if (!srst_n_i) begin
            m_run = 0; m_itag = 0; m_infl = 0; e_dv0 = 0; e_dv1 = 0;
        end else begin
            e_dv0 = x_ok0; e_dv1 = x_ok1;
            e_di0 = m_itag; e_di1 = (m_itag + 1) % ITAG_MOD;
            e_dr0 = int'(inst0_rd_i); e_dr1 = int'(inst1_rd_i);
            m_itag = (m_itag + acc) % ITAG_MOD;
            if (flush_i) m_infl = 0;
            else begin
                m_infl = m_infl + acc - int'(retire_cnt_i);
                if (m_infl < 0) m_infl = 0;
            end
            m_run = !flush_i;
        end
        @(negedge clk_i);
    endtask

    task automatic pair_clean(input int d0, input int d1);
        set_slots(1, 0, 0, d0, 1, 1, 0, 0, d1, 1);
    endtask

    initial begin
        srst_n_i = 0; flush_i = 0; retire_cnt_i = 2'd0; busy_flag_i = 32'd0;
        pair_clean(5, 6);
        @(posedge clk_i);
        @(negedge clk_i);
        m_run = 0; m_itag = 0; m_infl = 0; e_dv0 = 0; e_dv1 = 0;

        // Reset state with a valid pair presented
        #1;
        check("rst_accept", 32'(accept_o), 32'd0);
        check("rst_sb_clear", 32'(sb_clear_o), 32'd1);
        check("rst_sb0_write", 32'(sb0_write_o), 32'd0);
        check("rst_sb1_write", 32'(sb1_write_o), 32'd0);
        check("rst_disp0_valid", 32'(disp0_valid_o), 32'd0);
        check("rst_disp0_itag", 32'(disp0_itag_o), 32'd0);
        check("rst_disp1_rd", 32'(disp1_rd_o), 32'd0);
        check("rst_inflight", 32'(inflight_o), 32'd0);
        step();

        // IDLE cycle after release
        srst_n_i = 1;
        #1;
        check("idle_sb_clear", 32'(sb_clear_o), 32'd1);
        check("idle_accept", 32'(accept_o), 32'd0);
        step();

        // Hazard-free pair
        #1;
        check("pair_accept", 32'(accept_o), 32'd2);
        check("pair_sb0_rd", 32'(sb0_rdindex_o), 32'd5);
        check("pair_sb0_itag", 32'(sb0_itag_o), 32'd0);
        check("pair_sb1_rd", 32'(sb1_rdindex_o), 32'd6);
        check("pair_sb1_itag", 32'(sb1_itag_o), 32'd1);
        check("pair_sb1_write", 32'(sb1_write_o), 32'd1);
        step();
        check("pair_disp0_valid", 32'(disp0_valid_o), 32'd1);
        check("pair_disp1_valid", 32'(disp1_valid_o), 32'd1);
        check("pair_inflight", 32'(inflight_o), 32'd2);

        // Intra-pair RAW on x3
        set_slots(1, 0, 0, 3, 1, 1, 3, 0, 4, 1);
        #1;
        check("raw_accept", 32'(accept_o), 32'd1);
        check("raw_sb1_write", 32'(sb1_write_o), 32'd0);
        check("raw_sb0_itag", 32'(sb0_itag_o), 32'd2);
        step();
        check("raw_disp1_valid", 32'(disp1_valid_o), 32'd0);

        // Busy source x7 stalls, then clears
        busy_flag_i = 32'h0000_0081;
        set_slots(1, 0, 7, 8, 1, 1, 0, 0, 9, 1);
        #1;
        check("busy_accept", 32'(accept_o), 32'd0);
        step();
        busy_flag_i = 32'h0000_0001;
        #1;
        check("unbusy_accept", 32'(accept_o), 32'd2);
        check("unbusy_sb0_itag", 32'(sb0_itag_o), 32'd3);
        step();
        busy_flag_i = 32'd0;

        // Flush with a valid pair and a retire pending
        pair_clean(10, 11);
        flush_i = 1; retire_cnt_i = 2'd1;
        #1;
        check("flush_accept", 32'(accept_o), 32'd0);
        step();
        flush_i = 0; retire_cnt_i = 2'd0;
        #1;
        check("flush_inflight", 32'(inflight_o), 32'd0);
        check("flush_disp0_valid", 32'(disp0_valid_o), 32'd0);
        check("flush_sb_clear", 32'(sb_clear_o), 32'd1);
        check("flush_hold_accept", 32'(accept_o), 32'd0);
        step();
        #1;
        check("resume_accept", 32'(accept_o), 32'd2);
        check("resume_sb0_itag", 32'(sb0_itag_o), 32'd5);
        step();

        // Build up to 9 in flight, then reset over a flush and a retire
        for (int i = 0; i < 3; i++) begin pair_clean(12 + i, 20 + i); step(); end
        set_slots(1, 0, 0, 15, 1, 0, 0, 0, 16, 1);
        step();
        check("pre_rst_inflight", 32'(inflight_o), 32'd9);
        pair_clean(1, 2);
        srst_n_i = 0; flush_i = 1; retire_cnt_i = 2'd2;
        #1;
        check("midrst_accept", 32'(accept_o), 32'd0);
        check("midrst_sb_clear", 32'(sb_clear_o), 32'd1);
        check("midrst_sb0_write", 32'(sb0_write_o), 32'd0);
        step();
        check("midrst_inflight", 32'(inflight_o), 32'd0);
        check("midrst_disp1_valid", 32'(disp1_valid_o), 32'd0);
        check("midrst_disp1_itag", 32'(disp1_itag_o), 32'd0);
        srst_n_i = 1; flush_i = 0; retire_cnt_i = 2'd0;
        #1;
        check("post_rst_sb_clear", 32'(sb_clear_o), 32'd1);
        check("post_rst_accept", 32'(accept_o), 32'd0);
        step();

        // Drive the itag to 240 at zero credit use, then 15 singles
        retire_cnt_i = 2'd2;
        for (int i = 0; i < 120; i++) begin pair_clean(1 + i % 30, 2 + i % 29); step(); end
        retire_cnt_i = 2'd0;
        for (int i = 0; i < 15; i++) begin
            set_slots(1, 0, 0, 1 + i, 1, 0, 0, 0, 0, 0);
            step();
        end
        check("wrap_inflight", 32'(inflight_o), 32'd15);
        pair_clean(3, 4);
        #1;
        check("credit_accept", 32'(accept_o), 32'd1);
        check("credit_sb0_itag", 32'(sb0_itag_o), 32'd255);
        check("credit_sb1_write", 32'(sb1_write_o), 32'd0);
        step();
        retire_cnt_i = 2'd2;
        #1;
        check("full_accept", 32'(accept_o), 32'd0);
        step();
        retire_cnt_i = 2'd0;
        #1;
        check("freed_accept", 32'(accept_o), 32'd2);
        check("wrap_sb0_itag", 32'(sb0_itag_o), 32'd0);
        check("wrap_sb1_itag", 32'(sb1_itag_o), 32'd1);
        step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            srst_n_i     = ($urandom_range(0, 99) != 0);
            flush_i      = ($urandom_range(0, 15) == 0);
            retire_cnt_i = 2'($urandom_range(0, 2));
            busy_flag_i  = $urandom() & $urandom() & $urandom();
            set_slots($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                      $urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
